key_debounce: RTL and testbench

//   Input-side counterpart to the LED driver blocks: samples KEY_NUM

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_db_cell.sv | 115 +++++++++++
 rtl/key_debounce.sv | 35 +++
 tb/tb_key_debounce.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debounce slice: per-key FSM state codes and
// default timing for a 25 MHz system clock.
package key_debounce_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    localparam int          KEY_NUM_DEF  = 4;
    localparam logic        KEY_ACT_DEF  = 1'b0;
    localparam int unsigned DB_CYC_DEF   = 25 * 1000 * 20 - 1;
    localparam int unsigned LONG_CYC_DEF = 25 * 1000 * 1000 - 1;

endpackage

// File: rtl/key_debounce_db_cell.sv
// One key: two-flop synchroniser, debounce FSM, debounce and long-press
// counters, and the registered press/release/long pulses.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | key released and stable, key_level = 0
// ST_PRESS_DB | pin reads pressed, waiting DB_CYC+1 stable cycles
// ST_HELD     | press accepted, key_level = 1, long-press timer running
// ST_REL_DB   | pin reads released, waiting DB_CYC+1 stable cycles
module key_db_cell
    import key_debounce_pkg::*;
#(
    parameter logic        KEY_ACT  = KEY_ACT_DEF,
    parameter int unsigned DB_CYC   = DB_CYC_DEF,
    parameter int unsigned LONG_CYC = LONG_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DB_W   = $clog2(DB_CYC + 1);
    localparam int LONG_W = $clog2(LONG_CYC + 1);
    localparam logic [DB_W-1:0]   DB_TC   = DB_W'(DB_CYC);
    localparam logic [LONG_W-1:0] LONG_TC = LONG_W'(LONG_CYC);

    logic              sync1;
    logic              sync2;
    logic              s;
    logic [1:0]        state;
    logic [DB_W-1:0]   db_cnt;
    logic [LONG_W-1:0] long_cnt;
    logic              long_done;

    assign s = (sync2 == KEY_ACT);

    // Bring the asynchronous pin into the clk domain; reset reads as released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= ~KEY_ACT;
            sync2 <= ~KEY_ACT;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // Debounce FSM with its counters; pulse outputs default low every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            db_cnt      <= '0;
            long_cnt    <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state  <= ST_PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!s) begin
                        state <= ST_IDLE;
                    end else if (db_cnt == DB_TC) begin
                        state     <= ST_HELD;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                        long_cnt  <= '0;
                        long_done <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state  <= ST_REL_DB;
                        db_cnt <= '0;
                    end else if (long_cnt < LONG_TC) begin
                        long_cnt <= long_cnt + LONG_W'(1);
                    end else if (!long_done) begin
                        key_long  <= 1'b1;
                        long_done <= 1'b1;
                    end
                end
                ST_REL_DB: begin
                    // A bounce back to pressed resumes the long-press timer where it stopped.
                    if (s) begin
                        state <= ST_HELD;
                    end else if (db_cnt == DB_TC) begin
                        state       <= ST_IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces KEY_NUM independent push-buttons; each key gets its own cell.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int          KEY_NUM  = KEY_NUM_DEF,
    parameter logic        KEY_ACT  = KEY_ACT_DEF,
    parameter int unsigned DB_CYC   = DB_CYC_DEF,
    parameter int unsigned LONG_CYC = LONG_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        key_db_cell #(
            .KEY_ACT  (KEY_ACT),
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .key_in      (key_in[k]),
            .key_level   (key_level[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k]),
            .key_long    (key_long[k])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with short timing. The reference model treats each
// key as: the reported level flips once the synchronised pin has disagreed
// with it for DB+2 consecutive samples, and a long pulse fires on the
// (LG+1)-th cycle the key is seen steadily held after an accepted press.
module tb_key_debounce;

    localparam int KN = 4;
    localparam int DB = 3;
    localparam int LG = 9;

    logic          clk;
    logic          rst;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_level;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_long;

    key_debounce #(
        .KEY_NUM  (KN),
        .KEY_ACT  (1'b0),
        .DB_CYC   (DB),
        .LONG_CYC (LG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state
    logic [KN-1:0] m_s1, m_s2, m_lvl, m_done;
    logic [KN-1:0] m_press, m_rel, m_long;
    int            m_run  [KN];
    int            m_held [KN];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_done = '0;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k < KN; k++) begin
            m_run[k]  = 0;
            m_held[k] = 0;
        end
    endtask

    task automatic model_step(input logic [KN-1:0] pressed);
        m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k < KN; k++) begin
            logic s;
            s = m_s2[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = pressed[k];
            if (s != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == DB + 2) begin
                    m_run[k] = 0;
                    m_lvl[k] = s;
                    if (s) begin
                        m_press[k] = 1'b1;
                        m_held[k]  = 0;
                        m_done[k]  = 1'b0;
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end
            end else begin
                if (m_lvl[k] && m_run[k] == 0 && !m_done[k]) begin
                    m_held[k]++;
                    if (m_held[k] == LG + 1) begin
                        m_long[k] = 1'b1;
                        m_done[k] = 1'b1;
                    end
                end
                m_run[k] = 0;
            end
        end
    endtask

    // One clock: drive pins (1 = pressed), step the model at the edge, compare at negedge.
    task automatic cyc(input logic [KN-1:0] pressed);
        key_in = ~pressed;
        @(posedge clk);
        model_step(pressed);
        @(negedge clk);
        chk("level",   key_level,   m_lvl);
        chk("press",   key_press,   m_press);
        chk("release", key_release, m_rel);
        chk("long",    key_long,    m_long);
    endtask

    initial begin
        int p_at, l_at, r_at;
        int n_p, n_r, n_l;
        logic [KN-1:0] acc, pv;
        logic [KN-1:0] pins;
        int remain [KN];

        rst    = 1'b0;
        key_in = '1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_level",   key_level,   0);
        chk("rst_press",   key_press,   0);
        chk("rst_release", key_release, 0);
        chk("rst_long",    key_long,    0);
        rst = 1'b1;
        repeat (3) cyc('0);

        // clean press on key0 with long press and release
        p_at = -1; l_at = -1; r_at = -1;
        for (int i = 0; i < 30; i++) begin
            cyc(4'b0001);
            if (key_press[0] && p_at < 0) p_at = i;
            if (key_long[0]  && l_at < 0) l_at = i;
        end
        chk("press_latency", p_at, 6);
        chk("long_after_press", l_at - p_at, 10);
        chk("held_level", key_level, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0000);
            if (key_release[0] && r_at < 0) r_at = i;
        end
        chk("release_latency", r_at, 6);

        // press bounce on key1
        acc = '0;
        for (int i = 0; i < 3;  i++) begin cyc(4'b0010); acc |= key_press | key_release | key_long | key_level; end
        for (int i = 0; i < 2;  i++) begin cyc(4'b0000); acc |= key_press | key_release | key_long | key_level; end
        for (int i = 0; i < 3;  i++) begin cyc(4'b0010); acc |= key_press | key_release | key_long | key_level; end
        for (int i = 0; i < 10; i++) begin cyc(4'b0000); acc |= key_press | key_release | key_long | key_level; end
        chk("bounce_quiet", acc, 0);

        // release bounce on key2
        n_p = 0; n_r = 0;
        for (int i = 0; i < 10; i++) begin cyc(4'b0100); n_p += int'(key_press[2]); n_r += int'(key_release[2]); end
        for (int i = 0; i < 2;  i++) begin cyc(4'b0000); n_p += int'(key_press[2]); n_r += int'(key_release[2]); end
        for (int i = 0; i < 10; i++) begin cyc(4'b0100); n_p += int'(key_press[2]); n_r += int'(key_release[2]); end
        chk("relbounce_press_cnt", n_p, 1);
        chk("relbounce_rel_cnt", n_r, 0);
        chk("relbounce_level", key_level[2], 1);
        for (int i = 0; i < 12; i++) cyc(4'b0000);

        // short hold on key0
        n_p = 0; n_r = 0; n_l = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(i < 12 ? 4'b0001 : 4'b0000);
            n_p += int'(key_press[0]); n_r += int'(key_release[0]); n_l += int'(key_long[0]);
        end
        chk("short_press_cnt", n_p, 1);
        chk("short_rel_cnt", n_r, 1);
        chk("short_long_cnt", n_l, 0);

        // keys 0 and 3 together
        pv = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(4'b1001);
            if (key_press != 0 && pv == 0) pv = key_press;
        end
        chk("simul_press", pv, 4'b1001);
        for (int i = 0; i < 12; i++) cyc(4'b0000);

        // reset while key1 is held; still held afterwards
        for (int i = 0; i < 12; i++) cyc(4'b0010);
        rst = 1'b0;
        #1;
        chk("midrst_level", key_level, 0);
        chk("midrst_pulses", key_press | key_release | key_long, 0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("inrst_level", key_level, 0);
        end
        rst = 1'b1;
        p_at = -1;
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0010);
            if (key_press[1] && p_at < 0) p_at = i;
        end
        chk("post_rst_press", p_at, 6);
        for (int i = 0; i < 12; i++) cyc(4'b0000);

        // random per-key hold/release runs
        pins = '0;
        for (int k = 0; k < KN; k++) remain[k] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < KN; k++) begin
                if (remain[k] == 0) begin
                    pins[k]   = ~pins[k];
                    remain[k] = int'($urandom_range(1, 16));
                end
                remain[k]--;
            end
            cyc(pins);
        end
        for (int i = 0; i < 20; i++) cyc(4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
